memory_unloader: RTL and testbench
==================================

Name: memory_unloader

Overview:
Read-side counterpart of memory_loader. Holds a NUM_ROWS x WORD_WIDTH result buffer filled by the compute datapath through a random-access write port. On a dump request it streams every row, 0 to NUM_ROWS-1, out of a WORD_WIDTH-wide scan port with a valid/ready handshake, so the testbench or host can drain results one row per accepted beat.

Parameters:
WORD_WIDTH, 512, width of each buffer row and of scan_out.
NUM_ROWS, 128, number of rows; must be at least 2.
ADDR_WIDTH, $clog2(NUM_ROWS), row index width (derived, not overridden).

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
wr_en  input  1  write strobe from the compute side.
wr_addr  input  ADDR_WIDTH  row to write.
wr_data  input  WORD_WIDTH  row data.
dump_start  input  1  single-cycle request to begin streaming.
scan_ready  input  1  consumer accepts the current beat.
scan_out  output  WORD_WIDTH  current row data (registered).
scan_valid  output  1  scan_out holds a valid row.
dump_done  output  1  one-cycle pulse after the last row is accepted.
busy  output  1  high from dump start through the DONE state.

Behaviour:
- Reset (reset == 0, asynchronous): state = IDLE, row pointer = 0, scan_out = 0, scan_valid = 0, dump_done = 0, busy = 0. Buffer contents are not reset.
- Writes: when wr_en is high at a rising edge, mem[wr_addr] <= wr_data. Writes are accepted in every state. wr_addr >= NUM_ROWS is ignored.
- IDLE:
  - If dump_start is high: pointer <= 0, scan_out <= mem[0] (pre-write value if wr_en targets row 0 in the same cycle), scan_valid <= 1, busy <= 1, go to SEND.
  - scan_valid rises on the edge after dump_start (latency 1).
- SEND:
  - A beat is transferred on a rising edge where scan_valid && scan_ready.
  - On transfer with pointer < NUM_ROWS-1: pointer <= pointer+1 and scan_out <= mem[pointer+1], read before any same-cycle write. scan_valid stays 1, so back-to-back beats run at one row per cycle.
  - On transfer with pointer == NUM_ROWS-1: scan_valid <= 0, go to DONE.
  - While scan_ready is low: scan_out, scan_valid and pointer hold.
- DONE: dump_done = 1 for exactly this one cycle, busy = 1. Next state is IDLE, where busy and dump_done return to 0.
- dump_start while busy (SEND or DONE) is ignored; no restart and no queueing.
- Coherency:
  - A write to a row not yet loaded into scan_out is visible in the stream.
  - A write to the row currently on scan_out, or to an earlier row, does not change the current dump.
- Reset asserted mid-dump aborts immediately to the reset values. The next dump must start again with dump_start.
- Minimum dump duration with scan_ready held high: NUM_ROWS + 2 cycles from dump_start to the dump_done pulse.

Optional Feature:
Macro UNLOADER_PARITY_EN.
- Defined: adds output scan_parity (1 bit), registered alongside scan_out, equal to the XOR of all bits of the row loaded into scan_out (even parity). It resets to 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Fill rows i = 0..127 with {16{i[7:0]+32'hA5000000}} via wr_en, pulse dump_start, hold scan_ready = 1 -> scan_valid rises 1 cycle later, 128 consecutive beats match the written rows in order, dump_done pulses exactly at cycle 130 after dump_start, busy is then 0.
- Same fill, toggle scan_ready 1,0,0,1,... -> scan_out and scan_valid hold during stalls, no row is skipped or duplicated, exactly 128 transfers occur.
- During a dump, write row 100 = 512'hDEAD while the pointer is at 10, and write row 5 = 512'hBEEF while the pointer is at 10 -> row 100 streams DEAD, row 5 keeps its old value.
- Pulse dump_start again while busy at the beat for row 50 -> stream continues unchanged, only one dump_done pulse occurs.
- Assert reset = 0 at the beat for row 60 -> scan_valid, busy and dump_done go to 0 immediately. A new dump_start after reset is released streams from row 0, and earlier buffer contents are intact.
- With UNLOADER_PARITY_EN: row 3 = 512'h7 -> scan_parity = 1 on the row 3 beat; row 4 = 512'h3 -> scan_parity = 0.

Source files
------------

// File: rtl/memory_unloader.sv
// Result buffer with a valid/ready row-streaming dump port.
// Define UNLOADER_PARITY_EN to add the registered even-parity output scan_parity.
module memory_unloader #(
  parameter int  WORD_WIDTH = 512,
  parameter int  NUM_ROWS   = 128,
  localparam int ADDR_WIDTH = $clog2(NUM_ROWS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  dump_start,
  input  logic                  scan_ready,
  output logic [WORD_WIDTH-1:0] scan_out,
  output logic                  scan_valid,
  output logic                  dump_done,
  output logic                  busy
`ifdef UNLOADER_PARITY_EN
  ,output logic                 scan_parity
`endif
);

  // state | meaning
  // IDLE  | waiting for dump_start
  // SEND  | row at ptr presented on scan_out, waiting for scan_ready
  // DONE  | last row accepted, dump_done pulse
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [WORD_WIDTH-1:0] mem [NUM_ROWS];
  logic                  wr_ok;
  logic                  load;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [WORD_WIDTH-1:0] load_data;

  generate
    if ((1 << ADDR_WIDTH) == NUM_ROWS) begin : g_full_range
      assign wr_ok = 1'b1;
    end else begin : g_part_range
      assign wr_ok = (int'(wr_addr) < NUM_ROWS);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
  end

  // Rows are read with the pre-write contents, so a same-cycle write to the
  // row being loaded only shows up in a later dump.
  always_comb begin
    load      = 1'b0;
    load_addr = '0;
    case (state)
      IDLE: begin
        load = dump_start;
      end
      SEND: begin
        load      = scan_ready && (ptr != LAST_ROW);
        load_addr = ptr + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign load_data = mem[load_addr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      scan_out   <= '0;
      scan_valid <= 1'b0;
      dump_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (load) scan_out <= load_data;
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          busy      <= 1'b0;
          if (dump_start) begin
            ptr        <= '0;
            scan_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (scan_ready) begin
            if (ptr == LAST_ROW) begin
              scan_valid <= 1'b0;
              dump_done  <= 1'b1;
              state      <= DONE;
            end else begin
              ptr <= load_addr;
            end
          end
        end
        DONE: begin
          dump_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UNLOADER_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    scan_parity <= 1'b0;
    else if (load) scan_parity <= ^load_data;
  end
`endif

endmodule

// File: tb/tb_memory_unloader.sv
// Directed bench for memory_unloader: stream-level reference model checked
// every cycle, plus literal expectations on the captured beat sequence.
module tb_memory_unloader;
  localparam int W  = 512;
  localparam int N  = 128;
  localparam int AW = $clog2(N);

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          dump_start;
  logic          scan_ready;
  logic [W-1:0]  scan_out;
  logic          scan_valid;
  logic          dump_done;
  logic          busy;
`ifdef UNLOADER_PARITY_EN
  logic          scan_parity;
`endif

  memory_unloader #(.WORD_WIDTH(W), .NUM_ROWS(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dump_start (dump_start),
    .scan_ready (scan_ready),
    .scan_out   (scan_out),
    .scan_valid (scan_valid),
    .dump_done  (dump_done),
    .busy       (busy)
`ifdef UNLOADER_PARITY_EN
    ,.scan_parity(scan_parity)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int i);
    logic [31:0] w;
    logic [7:0]  lo;
    lo = i[7:0];
    w  = 32'hA500_0000 + {24'd0, lo};
    return {16{w}};
  endfunction

  // Reference model: buffer image plus the stream position.
  logic [W-1:0] mm [N];
  logic [W-1:0] golden [N];
  logic [W-1:0] m_data = '0;
  bit  m_valid = 0, m_busy = 0, m_done = 0;
  int  m_row = 0;
  int  cyc = 0;

  always @(posedge clock) cyc++;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_valid = 0; m_busy = 0; m_done = 0; m_row = 0; m_data = '0;
    end else begin
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_valid && scan_ready) begin
        if (m_row == N - 1) begin
          m_valid = 0;
          m_done  = 1;
        end else begin
          m_row++;
          m_data = mm[m_row];
        end
      end else if (!m_busy && dump_start) begin
        m_row = 0; m_data = mm[0]; m_valid = 1; m_busy = 1;
      end
      if (wr_en && int'(wr_addr) < N) mm[wr_addr] = wr_data;
    end
  end

  bit           run_chk = 0;
  logic [W-1:0] beats [$];
  bit           beat_par [$];
  int           first_valid = -1, done_cyc = -1, done_pulses = 0, start_cyc = 0;

  always @(negedge clock) begin
    if (run_chk) begin
      chk("scan_valid", W'(scan_valid), W'(m_valid));
      chk("busy", W'(busy), W'(m_busy));
      chk("dump_done", W'(dump_done), W'(m_done));
      chk("scan_out", scan_out, m_data);
`ifdef UNLOADER_PARITY_EN
      chk("scan_parity", W'(scan_parity), W'(^m_data));
      if (scan_valid && scan_ready) beat_par.push_back(scan_parity);
`endif
      if (scan_valid && scan_ready) beats.push_back(scan_out);
      if (scan_valid && first_valid < 0) first_valid = cyc;
      if (dump_done) begin
        done_pulses++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_dump;
    beats.delete();
    beat_par.delete();
    first_valid = -1;
    done_cyc    = -1;
    done_pulses = 0;
    start_cyc   = cyc;
    dump_start  = 1'b1;
    tick();
    dump_start  = 1'b0;
  endtask

  task automatic wait_done(input bit stall);
    for (int k = 0; k < 2000; k++) begin
      scan_ready = stall ? (k % 3 == 0) : 1'b1;
      tick();
      if (dump_done) break;
    end
    chk("done_seen", W'(dump_done), W'(1));
    tick();
    tick();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_beats"}, W'(beats.size()), W'(N));
    for (int k = 0; k < N && k < beats.size(); k++)
      chk($sformatf("%s_row%0d", tag, k), beats[k], golden[k]);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    dump_start = 1'b0; scan_ready = 1'b0;
    for (int i = 0; i < N; i++) begin mm[i] = '0; golden[i] = '0; end
    tick(); tick();
    chk("rst_valid", W'(scan_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(dump_done), W'(0));
    chk("rst_out", scan_out, '0);
    reset = 1'b1;
    run_chk = 1;
    tick();

    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = pat(i); golden[i] = pat(i);
      tick();
    end
    wr_en = 1'b0;

    // Full-rate dump
    scan_ready = 1'b1;
    start_dump();
    wait_done(0);
    check_stream("fast");
    chk("valid_latency", W'(first_valid - start_cyc), W'(1));
    chk("done_latency", W'(done_cyc - start_cyc + 1), W'(130));
    chk("busy_after", W'(busy), W'(0));
    chk("row0_literal", beats.size() > 0 ? beats[0] : '0, {16{32'hA500_0000}});
    chk("row127_literal", beats.size() > 127 ? beats[127] : '0, {16{32'hA500_007F}});

    // Stalled dump, ready pattern 1,0,0,1,...
    scan_ready = 1'b1;
    start_dump();
    wait_done(1);
    check_stream("stall");
    chk("stall_pulses", W'(done_pulses), W'(1));

    // Writes during a dump while row 10 is presented
    scan_ready = 1'b1;
    start_dump();
    repeat (10) tick();
    scan_ready = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(100); wr_data = W'(16'hDEAD);
    tick();
    wr_addr = AW'(5); wr_data = W'(16'hBEEF);
    tick();
    wr_en = 1'b0;
    wait_done(0);
    golden[100] = W'(16'hDEAD);
    check_stream("coh");
    chk("coh_row100", beats.size() > 100 ? beats[100] : '0, W'(16'hDEAD));
    chk("coh_row5", beats.size() > 5 ? beats[5] : '0, pat(5));
    golden[5] = W'(16'hBEEF);

    // dump_start while busy is ignored
    scan_ready = 1'b1;
    start_dump();
    repeat (50) tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    wait_done(0);
    tick();
    check_stream("restart");
    chk("restart_pulses", W'(done_pulses), W'(1));

    // Reset mid-dump at row 60
    scan_ready = 1'b1;
    start_dump();
    repeat (60) tick();
    chk("pre_rst_row60", scan_out, golden[60]);
    reset = 1'b0;
    #1;
    chk("async_valid", W'(scan_valid), W'(0));
    chk("async_busy", W'(busy), W'(0));
    chk("async_done", W'(dump_done), W'(0));
    chk("async_out", scan_out, '0);
    tick();
    reset = 1'b1;
    tick(); tick();
    start_dump();
    wait_done(0);
    check_stream("post_rst");

`ifdef UNLOADER_PARITY_EN
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = W'(3'h7);
    tick();
    wr_addr = AW'(4); wr_data = W'(2'h3);
    tick();
    wr_en = 1'b0;
    golden[3] = W'(3'h7);
    golden[4] = W'(2'h3);
    scan_ready = 1'b1;
    start_dump();
    wait_done(0);
    check_stream("par");
    chk("par_row3", W'(beat_par.size() > 3 ? beat_par[3] : 1'b0), W'(1));
    chk("par_row4", W'(beat_par.size() > 4 ? beat_par[4] : 1'b1), W'(0));
`endif

    run_chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
